// File: rtl/prng_pkg.sv
// Shared definitions for the prng_server block: FSM encoding and the default
// xorshift shift triplet / seed for the 16-bit configuration.
package prng_pkg;

  // Legacy-compatible state encodings, also exposed through the enum below.
  localparam logic [1:0] FSM_WARMUP = 2'd0;
  localparam logic [1:0] FSM_FILL   = 2'd1;
  localparam logic [1:0] FSM_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    WARMUP = FSM_WARMUP,
    FILL   = FSM_FILL,
    HOLD   = FSM_HOLD
  } prng_fsm_e;

  localparam int          DEF_SHL1 = 7;
  localparam int          DEF_SHR  = 9;
  localparam int          DEF_SHL2 = 8;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

endpackage

// File: rtl/xorshift_step.sv
// One combinational xorshift step with the entropy bit folded into the LSB.
// The result may be zero; the caller is responsible for the zero guard.
module xorshift_step
  import prng_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHL1  = DEF_SHL1,
  parameter int SHR   = DEF_SHR,
  parameter int SHL2  = DEF_SHL2
) (
  input  logic [WIDTH-1:0] s,
  input  logic             e_bit,
  output logic [WIDTH-1:0] state_nxt
);

  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] x3;

  // Shifts are applied to WIDTH-bit operands, so overflow bits simply fall off.
  assign x1        = s ^ (s << SHL1);
  assign x2        = x1 ^ (x1 >> SHR);
  assign x3        = x2 ^ (x2 << SHL2);
  assign state_nxt = x3 ^ {{(WIDTH-1){1'b0}}, e_bit};

endmodule

// File: rtl/prng_server.sv
// Xorshift PRNG fed by the entropy pool's serial bit, serving words to one
// consumer over valid/ready. Handles warm-up after reset/reseed and never lets
// the state become zero.
// Optional build macro: PRNG_HEALTH_EN adds a repetition-count health check
// that latches health_fail and stops serving words until reseed or reset.
module prng_server
  import prng_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               SHL1          = DEF_SHL1,
  parameter int               SHR           = DEF_SHR,
  parameter int               SHL2          = DEF_SHL2,
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(DEF_SEED),
  parameter int               WARMUP_CYCLES = 32,
  parameter int               REPEAT_LIMIT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e_bit,
  input  logic             reseed,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] r_word,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             health_fail
);

  localparam int               CNT_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);

  // Reject configurations that would lock the generator at zero or never serve.
  if (SEED == '0 || WARMUP_CYCLES < 1 || REPEAT_LIMIT < 1) begin : g_bad_params
    $error("prng_server: SEED must be nonzero; WARMUP_CYCLES and REPEAT_LIMIT must be >= 1");
  end

  prng_fsm_e        fsm;
  logic [CNT_W-1:0] warm_cnt;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] step_raw;
  logic [WIDTH-1:0] state_nxt;
  logic [WIDTH-1:0] seed_load;
  logic             xfer;
  logic             capture;
  logic             trip;

  xorshift_step #(
    .WIDTH (WIDTH),
    .SHL1  (SHL1),
    .SHR   (SHR),
    .SHL2  (SHL2)
  ) u_step (
    .s         (state),
    .e_bit     (e_bit),
    .state_nxt (step_raw)
  );

  // A zero state is a fixed point of xorshift, so both paths into the state
  // register substitute SEED for zero.
  assign state_nxt = (step_raw == '0) ? SEED : step_raw;
  assign seed_load = (seed_in == '0) ? SEED : seed_in;

  // A handshake on a reseed edge still completes: the consumer keeps r_word,
  // but no replacement word is captured because warm-up restarts.
  assign xfer    = r_valid && r_ready;
  assign capture = !reseed && ((fsm == FILL) || ((fsm == HOLD) && xfer));

  // Generator state: steps on every edge, reloaded on reseed.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state <= SEED;
    end else if (reseed) begin
      state <= seed_load;
    end else begin
      state <= state_nxt;
    end
  end

  // Warm-up sequencing and the consumer-facing word/valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= WARMUP;
      warm_cnt <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
    end else if (reseed) begin
      fsm      <= WARMUP;
      warm_cnt <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (fsm)
        WARMUP: begin
          warm_cnt <= warm_cnt + 1'b1;
          if (warm_cnt == CNT_LAST) begin
            fsm <= FILL;
          end
        end
        FILL, HOLD: fsm <= HOLD;
        default:    fsm <= WARMUP;
      endcase
      if (capture) begin
        r_word  <= state_nxt;
        r_valid <= !trip;
      end
    end
  end

`ifdef PRNG_HEALTH_EN
  localparam int RPT_W = $clog2(REPEAT_LIMIT + 1);

  logic [WIDTH-1:0] prev_word;
  logic [RPT_W-1:0] rep_cnt;
  logic [RPT_W-1:0] rep_inc;
  logic             same_word;
  logic             fail_q;

  assign same_word   = (state_nxt == prev_word);
  assign rep_inc     = rep_cnt + 1'b1;
  assign trip        = capture && same_word && (rep_inc == RPT_W'(REPEAT_LIMIT));
  assign health_fail = fail_q;

  // Repetition counter over captured words; a trip is sticky until reseed.
  // Once tripped, r_valid stays low so no further captures can happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_word <= '0;
      rep_cnt   <= '0;
      fail_q    <= 1'b0;
    end else if (reseed) begin
      rep_cnt <= '0;
      fail_q  <= 1'b0;
    end else if (capture) begin
      prev_word <= state_nxt;
      rep_cnt   <= same_word ? rep_inc : RPT_W'(1);
      if (trip) begin
        fail_q <= 1'b1;
      end
    end
  end
`else
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_prng_server.sv
// Self-checking bench for prng_server (WIDTH=16, WARMUP_CYCLES=1, REPEAT_LIMIT=2).
// A reference step function tracks the generator state; every offered word is
// pushed to a scoreboard queue and popped when the consumer accepts it.
module tb_prng_server;

  localparam logic [15:0] SEED_V = 16'hACE1;
  localparam int          WARM   = 1;
  localparam int          RL     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_bit = 1'b0;
  logic        reseed = 1'b0;
  logic [15:0] seed_in = '0;
  logic        r_ready = 1'b0;
  logic [15:0] r_word;
  logic        r_valid;
  logic        health_fail;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  bit          sb_on = 1'b1;
  logic [15:0] m_state = SEED_V;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  prng_server #(
    .WIDTH         (16),
    .SHL1          (7),
    .SHR           (9),
    .SHL2          (8),
    .SEED          (SEED_V),
    .WARMUP_CYCLES (WARM),
    .REPEAT_LIMIT  (RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .e_bit       (e_bit),
    .reseed      (reseed),
    .seed_in     (seed_in),
    .r_word      (r_word),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .health_fail (health_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic e);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    a = s ^ {s[8:0], 7'b0};
    b = a ^ {9'b0, a[15:9]};
    c = b ^ {b[7:0], 8'b0};
    c[0] = c[0] ^ e;
    return (c == 16'h0) ? SEED_V : c;
  endfunction

  // One clock edge: advance the model, score any transfer that happened on it.
  task automatic tick();
    bit          xfer;
    logic [15:0] w;
    xfer = (r_valid === 1'b1) && (r_ready === 1'b1);
    w    = r_word;
    @(posedge clk);
    if (reseed) m_state = (seed_in == 16'h0) ? SEED_V : seed_in;
    else        m_state = ref_step(m_state, e_bit);
    #1;
    if (xfer) begin
      n_xfer++;
      if (sb_on) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
        else                   check("xfer_word", {16'h0, w}, {16'h0, exp_q.pop_front()});
        if (!reseed) exp_q.push_back(m_state);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cnt0;
    logic [15:0] words[5];

    // Reset values while rst_n is held low.
    #12;
    check("rst_valid", {31'h0, r_valid}, 32'd0);
    check("rst_word", {16'h0, r_word}, 32'd0);
    check("rst_health", {31'h0, health_fail}, 32'd0);

    // Warm-up timing with no entropy.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("warm_valid", {31'h0, r_valid}, 32'd0);
    check("warm_state", {16'h0, dut.state}, 32'h0000D30F);
    tick();
    check("first_valid", {31'h0, r_valid}, 32'd1);
    check("first_word", {16'h0, r_word}, 32'h0000F1A5);
    exp_q.push_back(m_state);

    // Backpressure: word held stable while the state keeps stepping.
    for (int i = 0; i < 10; i++) begin
      e_bit = 1'($urandom_range(0, 1));
      tick();
      check("bp_word", {16'h0, r_word}, 32'h0000F1A5);
      check("bp_valid", {31'h0, r_valid}, 32'd1);
    end

    // Back-to-back acceptance of five words.
    r_ready = 1'b1;
    cnt0 = n_xfer;
    for (int i = 0; i < 5; i++) begin
      words[i] = r_word;
      e_bit = 1'($urandom_range(0, 1));
      tick();
    end
    check("burst_count", n_xfer - cnt0, 32'd5);
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        check("burst_distinct", {31'h0, words[i] != words[j]}, 32'd1);
    r_ready = 1'b0;
    e_bit   = 1'b0;

    // Asynchronous reset in HOLD, between clock edges.
    check("pre_rst_valid", {31'h0, r_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, r_valid}, 32'd0);
    check("arst_word", {16'h0, r_word}, 32'd0);
    check("arst_health", {31'h0, health_fail}, 32'd0);
    exp_q.delete();
    m_state = SEED_V;

    // Entropy mixing on the first edge only.
    @(negedge clk);
    rst_n = 1'b1;
    e_bit = 1'b1;
    tick();
    check("ent_state", {16'h0, dut.state}, 32'h0000D30E);
    e_bit = 1'b0;
    tick();
    check("ent_valid", {31'h0, r_valid}, 32'd1);
    check("ent_differs", {31'h0, r_word != 16'hF1A5}, 32'd1);
    check("ent_word", {16'h0, r_word}, {16'h0, m_state});
    exp_q.push_back(m_state);

    // Zero seed falls back to SEED and restarts warm-up.
    reseed  = 1'b1;
    seed_in = 16'h0000;
    tick();
    reseed = 1'b0;
    exp_q.delete();
    check("zs_drop", {31'h0, r_valid}, 32'd0);
    tick();
    check("zs_warm", {31'h0, r_valid}, 32'd0);
    tick();
    check("zs_valid", {31'h0, r_valid}, 32'd1);
    check("zs_word", {16'h0, r_word}, 32'h0000F1A5);
    exp_q.push_back(m_state);

    // Reseed on the same edge as a handshake.
    r_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_bit = 1'($urandom_range(0, 1));
      tick();
    end
    e_bit   = 1'b0;
    cnt0    = n_xfer;
    reseed  = 1'b1;
    seed_in = 16'h1234;
    tick();
    reseed = 1'b0;
    check("rs_one_xfer", n_xfer - cnt0, 32'd1);
    check("rs_valid0_a", {31'h0, r_valid}, 32'd0);
    tick();
    check("rs_valid0_b", {31'h0, r_valid}, 32'd0);
    tick();
    check("rs_valid1", {31'h0, r_valid}, 32'd1);
    check("rs_word", {16'h0, r_word}, {16'h0, m_state});
    exp_q.push_back(m_state);
    for (int i = 0; i < 4; i++) tick();
    check("rs_xfer_total", n_xfer - cnt0, 32'd5);

`ifdef PRNG_HEALTH_EN
    // Forced constant state makes every capture identical.
    r_ready = 1'b0;
    sb_on   = 1'b0;
    exp_q.delete();
    force dut.state = 16'h0F0F;
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("hf_flag", {31'h0, health_fail}, 32'd1);
    check("hf_valid", {31'h0, r_valid}, 32'd0);
    for (int i = 0; i < 2; i++) tick();
    check("hf_sticky", {31'h0, health_fail}, 32'd1);
    check("hf_still_idle", {31'h0, r_valid}, 32'd0);
    release dut.state;
    reseed  = 1'b1;
    seed_in = 16'h5555;
    tick();
    reseed = 1'b0;
    sb_on  = 1'b1;
    check("hf_clear", {31'h0, health_fail}, 32'd0);
    tick();
    tick();
    check("hf_resume_valid", {31'h0, r_valid}, 32'd1);
    check("hf_resume_word", {16'h0, r_word}, {16'h0, m_state});
`else
    check("hf_tied", {31'h0, health_fail}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
